// File: rtl/rgb2ycbcr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rgb2ycbcr_pipe
// Brief    : 8-bit RGB to BT.601 studio-range YCbCr converter. Three register
//            stages (products, sums, shift/clamp) under a single global
//            enable, with a user sideband carried alongside each pixel.
// Revision : 1.0 - initial release
// ============================================================================
module rgb2ycbcr_pipe #(
    parameter int USER_W       = 3,
    parameter bit CLAMP_STUDIO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_r,
    input  logic [7:0]        in_g,
    input  logic [7:0]        in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_y,
    output logic [7:0]        out_cb,
    output logic [7:0]        out_cr,
    output logic [USER_W-1:0] out_user
);

    // Coefficients are scaled by 256; the biases fold the +16/+128 offsets
    // together with the +128 round-half-up term applied before the shift.
    localparam logic signed [16:0] c_k_yr  =  17'sd66;
    localparam logic signed [16:0] c_k_yg  =  17'sd129;
    localparam logic signed [16:0] c_k_yb  =  17'sd25;
    localparam logic signed [16:0] c_k_cbr = -17'sd38;
    localparam logic signed [16:0] c_k_cbg = -17'sd74;
    localparam logic signed [16:0] c_k_cbb =  17'sd112;
    localparam logic signed [16:0] c_k_crr =  17'sd112;
    localparam logic signed [16:0] c_k_crg = -17'sd94;
    localparam logic signed [16:0] c_k_crb = -17'sd18;
    localparam logic signed [17:0] c_y_bias = 18'sd4224;
    localparam logic signed [17:0] c_c_bias = 18'sd32896;

    // Sign-extend a registered product into the accumulator width.
    function automatic logic signed [17:0] sx(input logic signed [16:0] p);
        sx = {p[16], p};
    endfunction

    // Saturate an already-shifted sum into [lo, hi].
    function automatic logic [7:0] clamp8(input logic signed [17:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        logic signed [17:0] lo_s;
        logic signed [17:0] hi_s;
        lo_s = $signed({10'd0, lo});
        hi_s = $signed({10'd0, hi});
        if (v < lo_s)      clamp8 = lo;
        else if (v > hi_s) clamp8 = hi;
        else               clamp8 = v[7:0];
    endfunction

    logic w_en;
    logic signed [16:0] w_r;
    logic signed [16:0] w_g;
    logic signed [16:0] w_b;
    logic [7:0] w_y_lo;
    logic [7:0] w_y_hi;
    logic [7:0] w_c_lo;
    logic [7:0] w_c_hi;
    logic signed [17:0] w_y_sh;
    logic signed [17:0] w_cb_sh;
    logic signed [17:0] w_cr_sh;

    // Stage 1: products
    logic                     s1_valid_d, s1_valid_q;
    logic [USER_W-1:0]        s1_user_d,  s1_user_q;
    logic signed [16:0]       s1_prod_d [9];
    logic signed [16:0]       s1_prod_q [9];
    // Stage 2: biased sums
    logic                     s2_valid_d, s2_valid_q;
    logic [USER_W-1:0]        s2_user_d,  s2_user_q;
    logic signed [17:0]       s2_y_d,  s2_y_q;
    logic signed [17:0]       s2_cb_d, s2_cb_q;
    logic signed [17:0]       s2_cr_d, s2_cr_q;
    // Stage 3: output registers
    logic                     out_valid_d, out_valid_q;
    logic [USER_W-1:0]        out_user_d,  out_user_q;
    logic [7:0]               out_y_d,  out_y_q;
    logic [7:0]               out_cb_d, out_cb_q;
    logic [7:0]               out_cr_d, out_cr_q;

    // Whole pipe advances together whenever the output slot is free or draining.
    assign w_en     = out_ready | ~out_valid_q;
    assign in_ready = w_en;

    assign w_r = $signed({9'd0, in_r});
    assign w_g = $signed({9'd0, in_g});
    assign w_b = $signed({9'd0, in_b});

    generate
        if (CLAMP_STUDIO) begin : g_studio_bounds
            assign w_y_lo = 8'd16;
            assign w_y_hi = 8'd235;
            assign w_c_lo = 8'd16;
            assign w_c_hi = 8'd240;
        end else begin : g_full_bounds
            assign w_y_lo = 8'd0;
            assign w_y_hi = 8'd255;
            assign w_c_lo = 8'd0;
            assign w_c_hi = 8'd255;
        end
    endgenerate

    assign w_y_sh  = s2_y_q  >>> 8;
    assign w_cb_sh = s2_cb_q >>> 8;
    assign w_cr_sh = s2_cr_q >>> 8;

    // Stage 1 next state: nine coefficient products, held while stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_user_d  = s1_user_q;
        for (int i = 0; i < 9; i++) s1_prod_d[i] = s1_prod_q[i];
        if (w_en) begin
            s1_valid_d   = in_valid;
            s1_user_d    = in_user;
            s1_prod_d[0] = c_k_yr  * w_r;
            s1_prod_d[1] = c_k_yg  * w_g;
            s1_prod_d[2] = c_k_yb  * w_b;
            s1_prod_d[3] = c_k_cbr * w_r;
            s1_prod_d[4] = c_k_cbg * w_g;
            s1_prod_d[5] = c_k_cbb * w_b;
            s1_prod_d[6] = c_k_crr * w_r;
            s1_prod_d[7] = c_k_crg * w_g;
            s1_prod_d[8] = c_k_crb * w_b;
        end
    end

    // Stage 2 next state: per-channel sums including offset and rounding.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_user_d  = s2_user_q;
        s2_y_d     = s2_y_q;
        s2_cb_d    = s2_cb_q;
        s2_cr_d    = s2_cr_q;
        if (w_en) begin
            s2_valid_d = s1_valid_q;
            s2_user_d  = s1_user_q;
            s2_y_d  = sx(s1_prod_q[0]) + sx(s1_prod_q[1]) + sx(s1_prod_q[2]) + c_y_bias;
            s2_cb_d = sx(s1_prod_q[3]) + sx(s1_prod_q[4]) + sx(s1_prod_q[5]) + c_c_bias;
            s2_cr_d = sx(s1_prod_q[6]) + sx(s1_prod_q[7]) + sx(s1_prod_q[8]) + c_c_bias;
        end
    end

    // Stage 3 next state: shift, clamp to the configured range.
    always_comb begin
        out_valid_d = out_valid_q;
        out_user_d  = out_user_q;
        out_y_d     = out_y_q;
        out_cb_d    = out_cb_q;
        out_cr_d    = out_cr_q;
        if (w_en) begin
            out_valid_d = s2_valid_q;
            out_user_d  = s2_user_q;
            out_y_d     = clamp8(w_y_sh,  w_y_lo, w_y_hi);
            out_cb_d    = clamp8(w_cb_sh, w_c_lo, w_c_hi);
            out_cr_d    = clamp8(w_cr_sh, w_c_lo, w_c_hi);
        end
    end

    // All pipeline state; reset clears valids and data so nothing in flight survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_user_q   <= '0;
            for (int i = 0; i < 9; i++) s1_prod_q[i] <= '0;
            s2_valid_q  <= 1'b0;
            s2_user_q   <= '0;
            s2_y_q      <= '0;
            s2_cb_q     <= '0;
            s2_cr_q     <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= '0;
            out_y_q     <= '0;
            out_cb_q    <= '0;
            out_cr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_user_q   <= s1_user_d;
            for (int i = 0; i < 9; i++) s1_prod_q[i] <= s1_prod_d[i];
            s2_valid_q  <= s2_valid_d;
            s2_user_q   <= s2_user_d;
            s2_y_q      <= s2_y_d;
            s2_cb_q     <= s2_cb_d;
            s2_cr_q     <= s2_cr_d;
            out_valid_q <= out_valid_d;
            out_user_q  <= out_user_d;
            out_y_q     <= out_y_d;
            out_cb_q    <= out_cb_d;
            out_cr_q    <= out_cr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_user  = out_user_q;
    assign out_y     = out_y_q;
    assign out_cb    = out_cb_q;
    assign out_cr    = out_cr_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb2ycbcr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb2ycbcr_pipe
// Brief    : Self-checking bench: a studio-clamp and a full-range instance
//            share one stimulus stream; a scoreboard checks every output
//            transfer against an integer model of the conversion equations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb2ycbcr_pipe;

    localparam int USER_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_r, in_g, in_b;
    logic [USER_W-1:0] in_user;
    logic              out_ready;

    logic              in_ready_s, out_valid_s;
    logic [7:0]        y_s, cb_s, cr_s;
    logic [USER_W-1:0] user_s;
    logic              in_ready_f, out_valid_f;
    logic [7:0]        y_f, cb_f, cr_f;
    logic [USER_W-1:0] user_f;

    int total  = 0;
    int passed = 0;

    logic [26:0] q_s [$];
    logic [26:0] q_f [$];

    always #5 clk = ~clk;

    rgb2ycbcr_pipe #(.USER_W(USER_W), .CLAMP_STUDIO(1'b1)) u_dut_studio (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_y(y_s), .out_cb(cb_s), .out_cr(cr_s), .out_user(user_s)
    );

    rgb2ycbcr_pipe #(.USER_W(USER_W), .CLAMP_STUDIO(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_f),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .out_valid(out_valid_f), .out_ready(out_ready),
        .out_y(y_f), .out_cb(cb_f), .out_cr(cr_f), .out_user(user_f)
    );

    // Integer reference of the conversion equations with selectable clamp.
    function automatic logic [23:0] model(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input bit studio);
        int ri, gi, bi, y, cb, cr, ylo, yhi, clo, chi;
        ri = int'(r); gi = int'(g); bi = int'(b);
        y  = ( 66*ri + 129*gi +  25*bi +  4096 + 128) >>> 8;
        cb = (-38*ri -  74*gi + 112*bi + 32768 + 128) >>> 8;
        cr = (112*ri -  94*gi -  18*bi + 32768 + 128) >>> 8;
        ylo = studio ? 16 : 0;  yhi = studio ? 235 : 255;
        clo = studio ? 16 : 0;  chi = studio ? 240 : 255;
        if (y  < ylo) y  = ylo; if (y  > yhi) y  = yhi;
        if (cb < clo) cb = clo; if (cb > chi) cb = chi;
        if (cr < clo) cr = clo; if (cr > chi) cr = chi;
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_s.delete();
            q_f.delete();
        end else begin
            if (in_valid && in_ready_s) begin
                q_s.push_back({in_user, model(in_r, in_g, in_b, 1'b1)});
                q_f.push_back({in_user, model(in_r, in_g, in_b, 1'b0)});
            end
            if (out_valid_s && out_ready) begin
                chk("sb_studio_nonempty", 32'(q_s.size() > 0), 32'd1);
                if (q_s.size() > 0)
                    chk("sb_studio_pixel", 32'({user_s, y_s, cb_s, cr_s}), 32'(q_s.pop_front()));
            end
            if (out_valid_f && out_ready) begin
                chk("sb_full_nonempty", 32'(q_f.size() > 0), 32'd1);
                if (q_f.size() > 0)
                    chk("sb_full_pixel", 32'({user_f, y_f, cb_f, cr_f}), 32'(q_f.pop_front()));
            end
        end
    end

    // Present one pixel and hold it until accepted (bounded wait).
    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [USER_W-1:0] u);
        int  n;
        logic acc;
        n = 0;
        in_r = r; in_g = g; in_b = b; in_user = u; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready_s;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        chk("drive_accept", 32'(acc), 32'd1);
    endtask

    // One pixel with out_ready high; check the exact 3-clock latency and value.
    task automatic colour(input string tag, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic [23:0] exp);
        in_r = r; in_g = g; in_b = b; in_user = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_not_early"}, 32'(out_valid_s), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid_s), 32'd1);
        chk({tag, "_ycbcr"}, 32'({y_s, cb_s, cr_s}), 32'(exp));
    endtask

    initial begin
        logic [26:0] hold;
        logic [2:0]  pat [3];
        int          acc_cnt;
        int          cyc;

        pat[0] = 3'b100; pat[1] = 3'b111; pat[2] = 3'b000;

        // Reset held two cycles with in_valid asserted.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_r = 8'd200; in_g = 8'd10; in_b = 8'd99; in_user = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_s", 32'(out_valid_s), 32'd0);
        chk("rst_valid_f", 32'(out_valid_f), 32'd0);
        chk("rst_data_s", 32'({user_s, y_s, cb_s, cr_s}), 32'd0);
        chk("rst_data_f", 32'({user_f, y_f, cb_f, cr_f}), 32'd0);
        rst_n = 1'b1;

        // Basic colours, each exactly 3 clocks after acceptance.
        colour("black", 8'd0,   8'd0,   8'd0,   {8'd16,  8'd128, 8'd128});
        colour("white", 8'd255, 8'd255, 8'd255, {8'd235, 8'd128, 8'd128});
        colour("red",   8'd255, 8'd0,   8'd0,   {8'd82,  8'd90,  8'd240});

        // Backpressure: 8-pixel stream with a 5-cycle stall in the middle.
        for (int i = 0; i < 4; i++)
            drive(8'(i * 31), 8'(255 - i * 20), 8'(i * 7 + 3), 3'(i));
        in_r = 8'd77; in_g = 8'd88; in_b = 8'd99; in_user = 3'd4; in_valid = 1'b1;
        out_ready = 1'b0;
        hold = {user_s, y_s, cb_s, cr_s};
        chk("stall_out_valid", 32'(out_valid_s), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 32'(in_ready_s), 32'd0);
            chk("stall_hold", 32'({user_s, y_s, cb_s, cr_s}), 32'(hold));
        end
        out_ready = 1'b1;
        drive(8'd77, 8'd88, 8'd99, 3'd4);
        for (int i = 5; i < 8; i++)
            drive(8'(i * 29), 8'(i * 3), 8'(250 - i * 11), 3'(i));
        in_valid = 1'b0;

        // Sideband pattern with random gaps between pixels.
        for (int i = 0; i < 9; i++) begin
            drive(8'($urandom), 8'($urandom), 8'($urandom), pat[i % 3]);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end

        // Reset with three pixels in flight (output stalled).
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(8'(50 + i), 8'(60 + i), 8'(70 + i), 3'b101);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(out_valid_s), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_ghost", 32'(out_valid_s), 32'd0);
        end
        colour("post_rst_red", 8'd255, 8'd0, 8'd0, {8'd82, 8'd90, 8'd240});

        // Random sweep: random pixels, random in_valid and out_ready.
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            in_user = 3'($urandom);
            @(negedge clk);
            if (in_valid && in_ready_s) acc_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("sweep_count", 32'(acc_cnt), 32'd10000);

        // Drain and confirm every accepted pixel came out.
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("drain_studio", 32'(q_s.size()), 32'd0);
        chk("drain_full", 32'(q_f.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
